// File: rtl/inc_seq_pkg.sv
// inc_seq_pkg: shared count width and FSM state encoding for inc_seq_ctrl
package inc_seq_pkg;
   localparam int CNT_W = 4;
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;
endpackage

// File: rtl/inc4_cla.sv
// inc4_cla: 4-bit carry-lookahead incrementer (carry-in 1, second operand 0)
module inc4_cla (
   input  logic [3:0] a,
   output logic [3:0] y,
   output logic       co
);
   logic [4:0] c;
   assign c  = {&a, &a[2:0], &a[1:0], a[0], 1'b1};
   assign y  = a ^ c[3:0];
   assign co = c[4];
endmodule

// File: rtl/inc_seq_ctrl.sv
// inc_seq_ctrl: start-to-end counting sequencer; define INC_SEQ_PAUSE_EN to add the pause input
module inc_seq_ctrl
   import inc_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] start_val,
   input  logic [CNT_W-1:0] end_val,
   input  logic             ack,
`ifdef INC_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);
   logic [1:0]       state;
   logic [CNT_W-1:0] end_r;
   logic [CNT_W-1:0] inc_y;
   logic             inc_co;
   logic             hold;
`ifdef INC_SEQ_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif
   inc4_cla u_inc (.a(count), .y(inc_y), .co(inc_co));
   assign busy = state == RUN;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         end_r <= '0;
         wrap  <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            count <= start_val;
            end_r <= end_val;
            wrap  <= 1'b0;
            state <= RUN;
         end
      end else if (state == RUN) begin
         if (!hold) begin
            if (count == end_r) state <= DONE;
            else begin
               count <= inc_y;
               wrap  <= wrap | inc_co;
            end
         end
      end else if (state == DONE) begin
         if (ack) state <= IDLE;
      end else state <= IDLE;
   end
endmodule

// File: tb/tb_inc_seq_ctrl.sv
// tb_inc_seq_ctrl: randomized self-checking bench for inc_seq_ctrl against a run-level model
module tb_inc_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [3:0] start_val = '0;
   logic [3:0] end_val = '0;
   logic       ack = 1'b0;
`ifdef INC_SEQ_PAUSE_EN
   logic       pause = 1'b0;
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   logic [3:0] count;
   logic       busy, done, wrap;
   int         total = 0;
   int         bad = 0;
   inc_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val),
      .end_val(end_val), .ack(ack),
`ifdef INC_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .count(count), .busy(busy), .done(done), .wrap(wrap)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic noise();
      start     = 1'($urandom);
      start_val = 4'($urandom);
      end_val   = 4'($urandom);
      ack       = 1'($urandom);
   endtask
   task automatic do_run(input logic [3:0] s, input logic [3:0] e, input int ackw,
                         input int pc, input int pl);
      int n, i, held;
      logic p;
      n = (int'(e) - int'(s) + 16) % 16;
      i = 0;
      held = 0;
      start = 1'b1; start_val = s; end_val = e; ack = 1'b0;
      step();
      while (i <= n) begin
         chk("run_busy", 4'(busy), 4'd1);
         chk("run_done", 4'(done), 4'd0);
         chk("run_count", count, 4'((int'(s) + i) % 16));
         chk("run_wrap", 4'(wrap), 4'((int'(s) + i) > 15));
         noise();
         p = PEN && i == pc && held < pl;
`ifdef INC_SEQ_PAUSE_EN
         pause = p;
`endif
         step();
         if (p) held++;
         else i++;
      end
`ifdef INC_SEQ_PAUSE_EN
      pause = 1'b0;
`endif
      for (int j = 0; j < ackw; j++) begin
         chk("done_done", 4'(done), 4'd1);
         chk("done_busy", 4'(busy), 4'd0);
         chk("done_count", count, e);
         chk("done_wrap", 4'(wrap), 4'((int'(s) + n) > 15));
         noise();
         ack = 1'b0;
         step();
      end
      chk("ack_done", 4'(done), 4'd1);
      ack = 1'b1; start = 1'b1; start_val = 4'($urandom); end_val = 4'($urandom);
      step();
      ack = 1'b0; start = 1'b0;
      chk("idle_done", 4'(done), 4'd0);
      chk("idle_busy", 4'(busy), 4'd0);
      chk("idle_count", count, e);
      chk("idle_wrap", 4'(wrap), 4'((int'(s) + n) > 15));
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("idle2_busy", 4'(busy), 4'd0);
      chk("idle2_count", count, e);
   endtask
   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_count", count, 4'd0);
      chk("rst_busy", 4'(busy), 4'd0);
      chk("rst_done", 4'(done), 4'd0);
      chk("rst_wrap", 4'(wrap), 4'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_hold", count, 4'd0);
      do_run(4'd3, 4'd7, 2, 99, 0);
      do_run(4'd14, 4'd1, 1, 99, 0);
      do_run(4'd9, 4'd9, 0, 99, 0);
      do_run(4'd0, 4'd3, 1, 1, 2);
      start = 1'b1; start_val = 4'd3; end_val = 4'd12;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_rst_count", count, 4'd5);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_count", count, 4'd0);
      chk("arst_busy", 4'(busy), 4'd0);
      chk("arst_done", 4'(done), 4'd0);
      chk("arst_wrap", 4'(wrap), 4'd0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("post_rst_done", 4'(done), 4'd0);
         chk("post_rst_busy", 4'(busy), 4'd0);
      end
      do_run(4'd5, 4'd2, 1, 99, 0);
      for (int r = 0; r < 24; r++)
         do_run(4'($urandom), 4'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 15), $urandom_range(0, 3));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
